addsub_seq_n: RTL and testbench
===============================

# addsub_seq_n

Registered, parametrised add/subtract unit with a signed accumulator, status flags, optional saturation and a valid/ready handshake on input and output. It is the next generation of the 6-bit combinational adder/subtractor in the ALU datapath: generalised to `WIDTH` bits, with one output register stage so the ALU can stall it, and an accumulate mode the 6-bit unit does not have. It sits between the ALU operand registers and the result mux.

## Interface
- `WIDTH`, 6: operand/result width in bits, ≥ 2; operands are two's-complement.
- `SATURATE`, 0: 1 clamps the result on signed overflow; 0 wraps.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  unit can accept this cycle.
- `op`  in  2  00 ADD (A+B), 01 SUB (A−B), 10 ACC_ADD (acc+A), 11 ACC_SUB (acc−A).
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B; ignored for ACC ops.
- `acc_clr`  in  1  clear the accumulator; sampled only on an accepted transfer.
- `out_valid`  out  1  result registered and pending.
- `out_ready`  in  1  consumer takes the result.
- `y`  out  WIDTH  result.
- `cout`  out  1  unsigned carry out; for subtraction, 1 = no borrow.
- `ovf`  out  1  signed overflow.
- `zero`  out  1  `y` == 0 after saturation.
- `neg`  out  1  MSB of `y` after saturation.
- `acc`  out  WIDTH  current accumulator value.

## Operation
- Accept = `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, combinational and with no dependence on `in_valid`.
- Arithmetic: WIDTH+1-bit sum of X + (sub ? ~Y : Y) + sub, where X = `a` for ADD/SUB and the base accumulator value for ACC ops, and Y = `b` for ADD/SUB and `a` for ACC ops. `cout` = bit WIDTH of this sum.
- `ovf`: the operands as added (X and the effective Y) have equal signs and the raw result sign differs.
- SATURATE=1 with `ovf`: `y` = 0111…1 if the true result is positive, 1000…0 if it is negative. `ovf` and `cout` still report the raw outcome.
- ACC ops: the base is `acc`, or 0 if `acc_clr` is asserted on the same accepted transfer. On accept, `acc` ← the (saturated) `y`.
- ADD/SUB with `acc_clr`=1: `acc` ← 0. Without `acc_clr`, ADD/SUB leave `acc` unchanged.
- Output register: on accept, `y`, the flags and `out_valid`=1 load together. If there is no accept and `out_ready`=1, `out_valid` ← 0. While `out_valid && !out_ready`, all outputs hold stable.
- Nothing changes on a non-accepted cycle, including `acc_clr`.

## Timing
- Latency 1: an operand accepted at edge n has its result visible after edge n. Throughput is 1 per cycle when `out_ready` stays high, because accept and drain overlap in the same cycle.
- Reset: `out_valid`=0, `y`=0, `cout`=0, `ovf`=0, `zero`=1, `neg`=0, `acc`=0. `in_ready`=1 in the first cycle after reset.
- Reset asserted mid-transfer drops the pending result; reset takes priority over accept.
- Back-to-back ACC ops chain correctly: each op uses the `acc` updated by the previous accept.

## Structure
- Package `addsub_pkg`: op encodings `OP_ADD`, `OP_SUB`, `OP_ACC_ADD`, `OP_ACC_SUB`, plus a flags struct {cout, ovf, zero, neg}.
- Sub-module `addsub_core`: purely combinational. It takes WIDTH and SATURATE, computes X ± Y, the saturation and all flags. It is instantiated once; the top level owns the handshake, the output register and `acc`.

## Test plan
All scenarios use WIDTH=6.
- SUB, a=30, b=15, SATURATE=0 -> `y`=15 (001111), `cout`=1, `ovf`=0, `zero`=0, `neg`=0, one cycle after accept.
- ADD, a=30, b=15 -> `y`=101101 (−19), `ovf`=1, `neg`=1, `cout`=0. Same stimulus with SATURATE=1 -> `y`=011111 (31), `ovf`=1.
- SUB, a=15, b=30 -> `y`=110001 (−15), `cout`=0, `neg`=1, `ovf`=0. SUB, a=−32, b=1 -> `ovf`=1; with SATURATE=1, `y`=100000.
- ACC_ADD a=20 with `acc_clr`=1, then ACC_ADD a=7, then ACC_SUB a=30, back-to-back with `out_ready`=1 -> `y`/`acc` sequence 20, 27, −3; one result per cycle.
- Backpressure: hold `out_ready`=0 after a result with `in_valid`=1, op=ACC_ADD -> `in_ready`=0, and `y`, flags and `acc` stay frozen for 5 cycles. Releasing `out_ready` accepts the pending op in the same cycle.
- Assert `rst` for one cycle while `out_valid`=1 with `acc`=27 -> all outputs take their reset values, and the next ACC_ADD a=5 yields 5.

Source files
------------

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared definitions for the registered add/subtract unit.
//               Holds the operation encodings and the packed status-flag
//               record that travels from the arithmetic core to the output
//               register.
// Revision    : 1.0  initial release
// ============================================================================
package addsub_pkg;

    // Operation select. Bit 1 picks accumulator mode and bit 0 picks
    // subtraction. The core decodes the two bits independently.
    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    // Status flags, registered alongside the result.
    typedef struct packed {
        logic cout;   // unsigned carry out; for subtraction 1 = no borrow
        logic ovf;    // signed overflow of the raw result
        logic zero;   // result == 0 after saturation
        logic neg;    // MSB of the result after saturation
    } flags_t;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_core.sv
`default_nettype none
// ============================================================================
// Module      : addsub_core
// Description : Purely combinational WIDTH-bit two's-complement add/subtract
//               with optional clamping on signed overflow and status flags.
//   Ports:
//     x_i      in  WIDTH  first operand (minuend for subtraction)
//     y_i      in  WIDTH  second operand (subtrahend for subtraction)
//     sub_i    in  1      1 = x - y, 0 = x + y
//     res_o    out WIDTH  result, saturated when SATURATE != 0
//     flags_o  out        {cout, ovf, zero, neg}
// Revision    : 1.0  initial release
// ============================================================================
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] res_o,
    output flags_t           flags_o
);

    localparam logic [WIDTH-1:0] C_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_y_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_raw;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    // Subtraction is x + ~y + 1; the carry-in rides on sub_i.
    assign w_y_eff = sub_i ? ~y_i : y_i;
    assign w_sum   = {1'b0, x_i} + {1'b0, w_y_eff} + {{WIDTH{1'b0}}, sub_i};
    assign w_raw   = w_sum[WIDTH-1:0];

    // Overflow is judged on the operands as actually added (x and the
    // effective y). This keeps x - MIN correct without special casing.
    assign w_ovf = (x_i[WIDTH-1] == w_y_eff[WIDTH-1]) &&
                   (w_raw[WIDTH-1] != x_i[WIDTH-1]);

    generate
        if (SATURATE != 0) begin : g_sat
            // On overflow both added operands share x's sign, so that sign
            // gives the direction of the true result.
            always_comb begin
                w_res = w_raw;
                if (w_ovf) begin
                    w_res = x_i[WIDTH-1] ? C_SAT_MIN : C_SAT_MAX;
                end
            end
        end else begin : g_wrap
            assign w_res = w_raw;
        end
    endgenerate

    assign res_o        = w_res;
    assign flags_o.cout = w_sum[WIDTH];
    assign flags_o.ovf  = w_ovf;
    assign flags_o.zero = (w_res == '0);
    assign flags_o.neg  = w_res[WIDTH-1];

endmodule : addsub_core
`default_nettype wire

// File: rtl/addsub_seq_n.sv
`default_nettype none
// ============================================================================
// Module      : addsub_seq_n
// Description : Registered add/subtract unit with a signed accumulator,
//               status flags, optional saturation and valid/ready handshakes.
//               There is one output register stage, so the latency is 1. A
//               new operand is accepted in the same cycle that the pending
//               result drains.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   input handshake (in_ready = !out_valid || out_ready)
//     op, a, b, acc_clr   operation, operands, accumulator clear
//     out_valid/out_ready output handshake
//     y, cout, ovf, zero, neg   registered result and flags
//     acc                 current accumulator value
// Revision    : 1.0  initial release
// ============================================================================
module addsub_seq_n
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [WIDTH-1:0] acc
);

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    flags_t           flags_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    logic             w_accept;
    logic             w_is_acc;
    logic             w_sub;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_res;
    flags_t           w_flags;

    // The consumer can stall the unit. A drain and a fresh accept may
    // happen in the same cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_is_acc = op[1];
    assign w_sub    = op[0];

    // In accumulator mode, the cleared base lets one transfer restart a sum.
    assign w_x = w_is_acc ? (acc_clr ? '0 : acc_q) : a;
    assign w_y = w_is_acc ? a : b;

    addsub_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .x_i     (w_x),
        .y_i     (w_y),
        .sub_i   (w_sub),
        .res_o   (w_res),
        .flags_o (w_flags)
    );

    always_comb begin
        acc_d = acc_q;
        if (w_accept) begin
            if (w_is_acc) begin
                acc_d = w_res;
            end else if (acc_clr) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '{cout: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
            acc_q       <= '0;
        end else begin
            acc_q <= acc_d;
            if (w_accept) begin
                out_valid_q <= 1'b1;
                y_q         <= w_res;
                flags_q     <= w_flags;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;
    assign acc       = acc_q;

endmodule : addsub_seq_n
`default_nettype wire

// File: tb/tb_addsub_seq_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_seq_n
// Description : Self-checking bench for addsub_seq_n at WIDTH=6. A wrapping
//               instance and a saturating instance share one set of inputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_seq_n;
    import addsub_pkg::*;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         acc_clr;
    logic         out_ready;

    logic         in_ready0, out_valid0, cout0, ovf0, zero0, neg0;
    logic [W-1:0] y0, acc0;
    logic         in_ready1, out_valid1, cout1, ovf1, zero1, neg1;
    logic [W-1:0] y1, acc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_seq_n #(.WIDTH(W), .SATURATE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .op(op), .a(a), .b(b), .acc_clr(acc_clr),
        .out_valid(out_valid0), .out_ready(out_ready),
        .y(y0), .cout(cout0), .ovf(ovf0), .zero(zero0), .neg(neg0), .acc(acc0)
    );

    addsub_seq_n #(.WIDTH(W), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .acc_clr(acc_clr),
        .out_valid(out_valid1), .out_ready(out_ready),
        .y(y1), .cout(cout1), .ovf(ovf1), .zero(zero1), .neg(neg1), .acc(acc1)
    );

    typedef struct {
        op_e          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y0;     // wrapping result
        logic [W-1:0] y1;     // saturating result
        logic         cout;
        logic         ovf;
        logic         zero0;
        logic         neg0;
        logic         zero1;
        logic         neg1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_e o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic clr);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        acc_clr  = clr;
    endtask

    initial begin
        // op, a, b, y0, y1, cout, ovf, zero0, neg0, zero1, neg1
        vecs[0] = '{OP_SUB, 6'd30, 6'd15, 6'd15, 6'd15, 1, 0, 0, 0, 0, 0};
        vecs[1] = '{OP_ADD, 6'd30, 6'd15, 6'b101101, 6'b011111, 0, 1, 0, 1, 0, 0};
        vecs[2] = '{OP_SUB, 6'd15, 6'd30, 6'b110001, 6'b110001, 0, 0, 0, 1, 0, 1};
        vecs[3] = '{OP_SUB, 6'b100000, 6'd1, 6'b011111, 6'b100000, 1, 1, 0, 0, 0, 1};
        vecs[4] = '{OP_ADD, 6'd10, 6'b110110, 6'd0, 6'd0, 1, 0, 1, 0, 1, 0};
        vecs[5] = '{OP_ADD, 6'b111111, 6'b111111, 6'b111110, 6'b111110, 1, 0, 0, 1, 0, 1};
        vecs[6] = '{OP_SUB, 6'd0, 6'b100000, 6'b100000, 6'b011111, 0, 1, 0, 1, 0, 0};
        vecs[7] = '{OP_ADD, 6'b100000, 6'b100000, 6'd0, 6'b100000, 1, 1, 1, 0, 0, 1};

        rst = 1'b1; in_valid = 1'b0; op = OP_ADD; a = '0; b = '0;
        acc_clr = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_y", y0, 0);
        chk("rst_cout", cout0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_zero", zero0, 1);
        chk("rst_neg", neg0, 0);
        chk("rst_acc", acc0, 0);
        chk("rst_in_ready", in_ready0, 1);

        // Table of ADD/SUB vectors, back-to-back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            step();
            chk($sformatf("v%0d_out_valid", i), out_valid0, 1);
            chk($sformatf("v%0d_y", i), y0, vecs[i].y0);
            chk($sformatf("v%0d_cout", i), cout0, vecs[i].cout);
            chk($sformatf("v%0d_ovf", i), ovf0, vecs[i].ovf);
            chk($sformatf("v%0d_zero", i), zero0, vecs[i].zero0);
            chk($sformatf("v%0d_neg", i), neg0, vecs[i].neg0);
            chk($sformatf("v%0d_sat_y", i), y1, vecs[i].y1);
            chk($sformatf("v%0d_sat_cout", i), cout1, vecs[i].cout);
            chk($sformatf("v%0d_sat_ovf", i), ovf1, vecs[i].ovf);
            chk($sformatf("v%0d_sat_zero", i), zero1, vecs[i].zero1);
            chk($sformatf("v%0d_sat_neg", i), neg1, vecs[i].neg1);
            chk($sformatf("v%0d_acc", i), acc0, 0);
        end

        // Accumulator chain: 20, 27, -3 with one result per cycle
        drive(OP_ACC_ADD, 6'd20, 6'd0, 1'b1);
        step();
        chk("chain0_y", y0, 20);
        chk("chain0_acc", acc0, 20);
        chk("chain0_in_ready", in_ready0, 1);
        drive(OP_ACC_ADD, 6'd7, 6'd0, 1'b0);
        step();
        chk("chain1_y", y0, 27);
        chk("chain1_acc", acc0, 27);
        chk("chain1_out_valid", out_valid0, 1);
        drive(OP_ACC_SUB, 6'd30, 6'd0, 1'b0);
        step();
        chk("chain2_y", y0, 6'b111101);
        chk("chain2_acc", acc0, 6'b111101);
        chk("chain2_neg", neg0, 1);
        chk("chain2_cout", cout0, 0);
        chk("chain2_sat_acc", acc1, 6'b111101);

        // Backpressure: pending ACC_ADD 4 stays stalled for 5 cycles
        drive(OP_ACC_ADD, 6'd4, 6'd0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", in_ready0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp%0d_y", i), y0, 6'b111101);
            chk($sformatf("bp%0d_acc", i), acc0, 6'b111101);
            chk($sformatf("bp%0d_neg", i), neg0, 1);
            chk($sformatf("bp%0d_out_valid", i), out_valid0, 1);
            chk($sformatf("bp%0d_in_ready", i), in_ready0, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready0, 1);
        step();
        chk("bp_release_y", y0, 1);
        chk("bp_release_acc", acc0, 1);

        // acc_clr on a stalled (non-accepted) cycle must not clear acc
        out_ready = 1'b0;
        drive(OP_ADD, 6'd0, 6'd0, 1'b1);
        step();
        chk("stall_clr_acc", acc0, 1);
        chk("stall_clr_y", y0, 1);

        // ADD without clear leaves acc; ADD with clear zeroes it
        out_ready = 1'b1;
        drive(OP_ADD, 6'd1, 6'd1, 1'b0);
        step();
        chk("add_noclr_y", y0, 2);
        chk("add_noclr_acc", acc0, 1);
        drive(OP_ADD, 6'd3, 6'd1, 1'b1);
        step();
        chk("add_clr_y", y0, 4);
        chk("add_clr_acc", acc0, 0);

        // Drain with no new input
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", out_valid0, 0);

        // Reset mid-transfer with acc=27 and a competing accept
        drive(OP_ACC_ADD, 6'd27, 6'd0, 1'b1);
        step();
        chk("pre_rst_acc", acc0, 27);
        drive(OP_ACC_ADD, 6'd9, 6'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid0, 0);
        chk("mid_rst_y", y0, 0);
        chk("mid_rst_zero", zero0, 1);
        chk("mid_rst_neg", neg0, 0);
        chk("mid_rst_cout", cout0, 0);
        chk("mid_rst_ovf", ovf0, 0);
        chk("mid_rst_acc", acc0, 0);
        drive(OP_ACC_ADD, 6'd5, 6'd0, 1'b0);
        step();
        chk("post_rst_y", y0, 5);
        chk("post_rst_acc", acc0, 5);
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_addsub_seq_n
`default_nettype wire
